// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 serial source and the div_by_5 checker:
// FSM state encoding, residue width and the residue transition table.
package mod5_pkg;

   localparam int RES_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAD   = 2'd2
   } tx_state_e;

   // (2r + b) mod 5 as an explicit table; out-of-range residues collapse to 0.
   function automatic logic [RES_W-1:0] mod5_next(input logic [RES_W-1:0] r, input logic b);
      logic [RES_W-1:0] nxt;
      case (r)
         3'd0:    nxt = b ? 3'd1 : 3'd0;
         3'd1:    nxt = b ? 3'd3 : 3'd2;
         3'd2:    nxt = b ? 3'd0 : 3'd4;
         3'd3:    nxt = b ? 3'd2 : 3'd1;
         3'd4:    nxt = b ? 3'd4 : 3'd3;
         default: nxt = 3'd0;
      endcase
      return nxt;
   endfunction

   function automatic logic [RES_W-1:0] mod5_pad(input logic [RES_W-1:0] r);
      return mod5_next(r, 1'b0);
   endfunction

endpackage

// File: rtl/mod5_residue.sv
// Running mod-5 residue register: clear restarts at 0, enable folds in one bit.
module mod5_residue
   import mod5_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [RES_W-1:0] residue
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         residue <= '0;
      end else if (clr) begin
         residue <= '0;
      end else if (en) begin
         residue <= mod5_next(residue, bit_in);
      end
   end

endmodule

// File: rtl/mod5_serial_tx.sv
// MSB-first serial word source with running mod-5 residue.
// Define MOD5_PAD_EN to append 3 pad bits that make every stream a multiple of 5.
module mod5_serial_tx
   import mod5_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             en,
   output logic             dout,
   output logic             dout_valid,
   output logic             last,
   output logic [RES_W-1:0] residue,
   output logic             done
);

   // Counter must also hold the pad index 2 for very narrow words.
   localparam int CNT_W = (WIDTH > 4) ? $clog2(WIDTH) : 2;

   tx_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] sreg;
   logic             done_q, done_nxt;
   logic             accept;
   logic             step;
`ifdef MOD5_PAD_EN
   logic [2:0]       padsr;
   logic             pad_load;
`endif

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      done_nxt   = 1'b0;
      accept     = 1'b0;
      step       = 1'b0;
      s_ready    = 1'b0;
      dout       = 1'b0;
      dout_valid = 1'b0;
      last       = 1'b0;
`ifdef MOD5_PAD_EN
      pad_load   = 1'b0;
`endif
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
               cnt_nxt   = CNT_W'(WIDTH - 1);
            end
         end
         SHIFT: begin
            dout       = sreg[WIDTH-1];
            dout_valid = 1'b1;
`ifndef MOD5_PAD_EN
            last       = (cnt == '0);
`endif
            if (en) begin
               step = 1'b1;
               if (cnt == '0) begin
`ifdef MOD5_PAD_EN
                  state_nxt = PAD;
                  cnt_nxt   = CNT_W'(2);
                  pad_load  = 1'b1;
`else
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
`endif
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
         end
`ifdef MOD5_PAD_EN
         PAD: begin
            dout       = padsr[2];
            dout_valid = 1'b1;
            last       = (cnt == '0);
            if (en) begin
               step = 1'b1;
               if (cnt == '0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   // Datapath registers carry no reset; outputs are gated by state.
   always_ff @(posedge clk) begin
      if (accept) begin
         sreg <= s_data;
      end else if (step && state == SHIFT) begin
         sreg <= {sreg[WIDTH-2:0], 1'b0};
      end
   end

`ifdef MOD5_PAD_EN
   // Pad value derives from the residue including the final data bit.
   always_ff @(posedge clk) begin
      if (pad_load) begin
         padsr <= mod5_pad(mod5_next(residue, dout));
      end else if (step && state == PAD) begin
         padsr <= {padsr[1:0], 1'b0};
      end
   end
`endif

   mod5_residue u_residue (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (accept),
      .en      (step),
      .bit_in  (dout),
      .residue (residue)
   );

   assign done = done_q;

endmodule

// File: tb/tb_mod5_serial_tx.sv
// Directed bench for mod5_serial_tx; expectations follow MOD5_PAD_EN when defined.
module tb_mod5_serial_tx;

   localparam int WIDTH = 8;
`ifdef MOD5_PAD_EN
   localparam int PADN = 3;
`else
   localparam int PADN = 0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [WIDTH-1:0] s_data = '0;
   logic             en = 1'b1;
   logic             dout;
   logic             dout_valid;
   logic             last;
   logic [2:0]       residue;
   logic             done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] o_bits;
   int          o_nbits, o_lat, o_vcyc, o_last_cnt, o_last_idx;
   logic        o_frozen, o_to, o_rdy_done, o_busy_rdy;
   logic [2:0]  o_res;

   always #5 clk = ~clk;

   mod5_serial_tx #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .en         (en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .last       (last),
      .residue    (residue),
      .done       (done)
   );

   // Sends one word, optionally stalling en for stall_len cycles once stall_at bits
   // have gone out; s_valid stays high through the stream to show it is ignored.
   task automatic send_word(input logic [WIDTH-1:0] w, input int stall_at, input int stall_len);
      int         stalled;
      logic       held_bit;
      logic [2:0] held_res;
      stalled = 0; held_bit = 1'b0; held_res = '0;
      o_bits = '0; o_nbits = 0; o_lat = 0; o_vcyc = 0; o_last_cnt = 0; o_last_idx = -1;
      o_frozen = 1'b1; o_to = 1'b1; o_rdy_done = 1'b0; o_busy_rdy = 1'b0; o_res = '0;
      @(negedge clk);
      s_data = w; s_valid = 1'b1; en = 1'b1;
      @(posedge clk);
      #1 s_data = ~w;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         o_lat = c;
         if (done) begin
            o_to = 1'b0; o_rdy_done = s_ready; o_res = residue;
            break;
         end
         if (dout_valid) begin
            o_vcyc++;
            if (s_ready) o_busy_rdy = 1'b1;
            if (o_nbits == stall_at && stalled < stall_len) begin
               if (stalled > 0 && (dout !== held_bit || residue !== held_res)) o_frozen = 1'b0;
               held_bit = dout; held_res = residue; en = 1'b0; stalled++;
            end else begin
               if (stalled > 0 && o_nbits == stall_at && dout !== held_bit) o_frozen = 1'b0;
               en = 1'b1;
               o_bits = {o_bits[14:0], dout};
               if (last) begin
                  o_last_cnt++; o_last_idx = o_nbits; s_valid = 1'b0;
               end
               o_nbits++;
            end
         end
      end
      s_valid = 1'b0; en = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; s_valid = 1'b0; en = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", s_ready); end
      n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid: got %b expected 0", dout_valid); end
      n_tests++; if (residue !== 3'd0) begin n_fail++; $display("FAIL rst_residue: got %0d expected 0", residue); end
      n_tests++; if ({done, last, dout} !== 3'b000) begin n_fail++; $display("FAIL rst_done_last_dout: got %b expected 000", {done, last, dout}); end
      rstn = 1'b1;
      @(negedge clk);
      n_tests++; if (s_ready !== 1'b1 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got rdy=%b vld=%b expected rdy=1 vld=0", s_ready, dout_valid); end
   endtask

   task automatic test_basic();
      logic [15:0] e_bits;
      e_bits = (PADN == 3) ? 16'h0050 : 16'h000A;
      send_word(8'h0A, -1, 0);
      n_tests++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL w0A_timeout: got no done expected done"); end
      n_tests++; if (o_bits !== e_bits) begin n_fail++; $display("FAIL w0A_bits: got %h expected %h", o_bits, e_bits); end
      n_tests++; if (o_nbits != WIDTH + PADN) begin n_fail++; $display("FAIL w0A_nbits: got %0d expected %0d", o_nbits, WIDTH + PADN); end
      n_tests++; if (o_lat != WIDTH + PADN + 1) begin n_fail++; $display("FAIL w0A_done_cycle: got %0d expected %0d", o_lat, WIDTH + PADN + 1); end
      n_tests++; if (o_last_cnt != 1 || o_last_idx != WIDTH + PADN - 1) begin n_fail++; $display("FAIL w0A_last: got cnt=%0d idx=%0d expected cnt=1 idx=%0d", o_last_cnt, o_last_idx, WIDTH + PADN - 1); end
      n_tests++; if (o_res !== 3'd0) begin n_fail++; $display("FAIL w0A_residue: got %0d expected 0", o_res); end
      n_tests++; if (o_rdy_done !== 1'b1 || o_busy_rdy !== 1'b0) begin n_fail++; $display("FAIL w0A_ready: got done_rdy=%b busy_rdy=%b expected 1 0", o_rdy_done, o_busy_rdy); end
      @(negedge clk);
      n_tests++; if (done !== 1'b0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL w0A_done_pulse: got done=%b vld=%b expected 0 0", done, dout_valid); end
   endtask

   task automatic test_residue();
      logic [7:0]  w_tab [4] = '{8'h07, 8'h09, 8'h06, 8'h08};
      logic [2:0]  r_tab [4] = '{3'd2, 3'd4, 3'd1, 3'd3};
      logic [15:0] p_tab [4] = '{16'h003C, 16'h004B, 16'h0032, 16'h0041};
      logic [15:0] e_bits;
      logic [2:0]  e_res;
      for (int i = 0; i < 4; i++) begin
         e_bits = (PADN == 3) ? p_tab[i] : {8'h00, w_tab[i]};
         e_res  = (PADN == 3) ? 3'd0 : r_tab[i];
         send_word(w_tab[i], -1, 0);
         n_tests++; if (o_bits !== e_bits || o_to !== 1'b0) begin n_fail++; $display("FAIL res_bits_%h: got %h to=%b expected %h", w_tab[i], o_bits, o_to, e_bits); end
         n_tests++; if (o_res !== e_res) begin n_fail++; $display("FAIL res_final_%h: got %0d expected %0d", w_tab[i], o_res, e_res); end
      end
      @(negedge clk);
      n_tests++; if (residue !== e_res) begin n_fail++; $display("FAIL res_hold: got %0d expected %0d", residue, e_res); end
   endtask

   task automatic test_pad_ff();
      logic [15:0] e_bits;
      e_bits = (PADN == 3) ? 16'h07F8 : 16'h00FF;
      send_word(8'hFF, -1, 0);
      n_tests++; if (o_bits !== e_bits || o_to !== 1'b0) begin n_fail++; $display("FAIL wFF_bits: got %h to=%b expected %h", o_bits, o_to, e_bits); end
      n_tests++; if (o_res !== 3'd0) begin n_fail++; $display("FAIL wFF_residue: got %0d expected 0", o_res); end
   endtask

   task automatic test_stall();
      logic [15:0] e_bits;
      e_bits = (PADN == 3) ? 16'h0528 : 16'h00A5;
      send_word(8'hA5, 4, 3);
      n_tests++; if (o_bits !== e_bits || o_to !== 1'b0) begin n_fail++; $display("FAIL stall_bits: got %h to=%b expected %h", o_bits, o_to, e_bits); end
      n_tests++; if (o_vcyc != WIDTH + PADN + 3) begin n_fail++; $display("FAIL stall_bit_cycles: got %0d expected %0d", o_vcyc, WIDTH + PADN + 3); end
      n_tests++; if (o_lat != WIDTH + PADN + 4) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected %0d", o_lat, WIDTH + PADN + 4); end
      n_tests++; if (o_frozen !== 1'b1) begin n_fail++; $display("FAIL stall_frozen: got %b expected 1", o_frozen); end
      n_tests++; if (o_res !== 3'd0) begin n_fail++; $display("FAIL stall_residue: got %0d expected 0", o_res); end
   endtask

   task automatic test_abort();
      logic        seen_done;
      logic [15:0] e_bits;
      e_bits = (PADN == 3) ? 16'h0028 : 16'h0005;
      seen_done = 1'b0;
      @(negedge clk);
      s_data = 8'hC3; s_valid = 1'b1; en = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++; if (residue !== 3'd1) begin n_fail++; $display("FAIL abort_pre_residue: got %0d expected 1", residue); end
      rstn = 1'b0;
      #1;
      n_tests++; if (dout_valid !== 1'b0 || residue !== 3'd0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL abort_async: got vld=%b res=%0d rdy=%b expected 0 0 1", dout_valid, residue, s_ready); end
      repeat (2) begin @(negedge clk); if (done) seen_done = 1'b1; end
      rstn = 1'b1;
      repeat (2) begin @(negedge clk); if (done) seen_done = 1'b1; end
      n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
      send_word(8'h05, -1, 0);
      n_tests++; if (o_bits !== e_bits || o_to !== 1'b0) begin n_fail++; $display("FAIL abort_next_bits: got %h to=%b expected %h", o_bits, o_to, e_bits); end
      n_tests++; if (o_res !== 3'd0) begin n_fail++; $display("FAIL abort_next_residue: got %0d expected 0", o_res); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_residue();
      test_pad_ff();
      test_stall();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
